// File: rtl/ad_rom_arb_pkg.sv
// Shared types and sizes for the A/D ROM arbiter.
// Includes the request-pick helper used by the 2-way arbiter.
package ad_rom_arb_pkg;

  localparam int AD_ROM_ADDR_W = 7;
  localparam int AD_ROM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } arb_state_e;

  // One-hot grant for two requesters; on a tie the requester not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] g;
    g = req;
    if (req == 2'b11) begin
      g = last_grant ? 2'b01 : 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/ad_rom_rr_arb2.sv
// 2-way combinational grant plus last_grant history; round-robin by default,
// fixed priority (requester 0 wins ties) when AD_ROM_ARB_FIXED_PRIO_EN is defined.
module ad_rom_rr_arb2
  import ad_rom_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

`ifdef AD_ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`else
  always_comb begin
    grant = rr_pick(req, last_grant);
  end
`endif

  // Reset value 1 makes requester 0 win the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/ad_rom_arbiter.sv
// Shares the single-port A/D ROM between two requesters; one access per 3 clk, ack to rvalid 3 clk.
// Tie-break is round-robin unless AD_ROM_ARB_FIXED_PRIO_EN is defined (requester 0 always wins).
module ad_rom_arbiter
  import ad_rom_arb_pkg::*;
#(
  parameter int ADDR_W = AD_ROM_ADDR_W,
  parameter int DATA_W = AD_ROM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_readdata
);

  arb_state_e state_q, state_n;
  logic [1:0] grant;
  logic       arb_point;
  logic       arb_en;
  logic       gnt_id_q;

  // Arbitration happens in IDLE and overlaps the rvalid cycle of the previous access.
  assign arb_point = (state_q == IDLE) || (state_q == CAPTURE);
  assign arb_en    = arb_point && (req0 || req1) && !reset;

  ad_rom_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .update (arb_en),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (arb_en) begin
          ack0    = grant[0];
          ack1    = grant[1];
          state_n = GRANT;
        end
      end
      GRANT: begin
        state_n = WAIT;
      end
      WAIT: begin
        state_n = CAPTURE;
      end
      CAPTURE: begin
        rvalid0 = !gnt_id_q;
        rvalid1 = gnt_id_q;
        if (arb_en) begin
          ack0    = grant[0];
          ack1    = grant[1];
          state_n = GRANT;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      gnt_id_q    <= 1'b0;
    end else if (arb_en) begin
      rom_address <= grant[1] ? addr1 : addr0;
      gnt_id_q    <= grant[1];
    end
  end

  // The ROM output is valid during WAIT; only the granted requester's word moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state_q == WAIT) begin
      if (gnt_id_q) begin
        rdata1 <= rom_readdata;
      end else begin
        rdata0 <= rom_readdata;
      end
    end
  end

endmodule

// File: tb/tb_ad_rom_arbiter.sv
// Bench for ad_rom_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model (an access occupies 3 clk after its ack, rvalid 3 clk after ack).
module tb_ad_rom_arbiter;

`ifdef AD_ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [6:0]  addr [2];
  logic        ack0, ack1, rvalid0, rvalid1, busy;
  logic [15:0] rdata0, rdata1;
  logic [6:0]  rom_address;
  logic [6:0]  rom_addr_q;
  logic [15:0] rom_readdata;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // ROM: registered address, word[n] = A500 + n.
  always @(posedge clk) rom_addr_q <= rom_address;
  assign rom_readdata = 16'hA500 + {9'd0, rom_addr_q};

  ad_rom_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req[0]),
    .req1         (req[1]),
    .addr0        (addr[0]),
    .addr1        (addr[1]),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .busy         (busy),
    .rom_address  (rom_address),
    .rom_readdata (rom_readdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int          t = 0;
  int          next_arb = 0;
  int          last_ack = -10;
  int          due [2] = '{-1, -1};
  logic [15:0] pend_dat [2];
  logic [15:0] exp_rdata [2] = '{16'h0, 16'h0};
  logic [6:0]  exp_addr = 7'h0;
  int          last_gnt = 1;
  bit          seen_ack [2] = '{1'b0, 1'b0};
  int          win;
  logic [1:0]  e_ack;

  always @(negedge clk) begin
    t++;
    seen_ack[0] = ack0;
    seen_ack[1] = ack1;
    if (reset) begin
      check_eq("rst_ack0", {31'd0, ack0}, 32'd0);
      check_eq("rst_ack1", {31'd0, ack1}, 32'd0);
      check_eq("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
      check_eq("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_rdata0", {16'd0, rdata0}, 32'd0);
      check_eq("rst_rdata1", {16'd0, rdata1}, 32'd0);
      check_eq("rst_rom_address", {25'd0, rom_address}, 32'd0);
      next_arb = 0;
      last_ack = -10;
      due = '{-1, -1};
      exp_rdata = '{16'h0, 16'h0};
      exp_addr = 7'h0;
      last_gnt = 1;
    end else begin
      if (t == due[0]) exp_rdata[0] = pend_dat[0];
      if (t == due[1]) exp_rdata[1] = pend_dat[1];
      check_eq("rvalid0", {31'd0, rvalid0}, {31'd0, (t == due[0])});
      check_eq("rvalid1", {31'd0, rvalid1}, {31'd0, (t == due[1])});
      check_eq("rdata0", {16'd0, rdata0}, {16'd0, exp_rdata[0]});
      check_eq("rdata1", {16'd0, rdata1}, {16'd0, exp_rdata[1]});
      check_eq("busy", {31'd0, busy}, {31'd0, (t > last_ack && t <= last_ack + 3)});
      check_eq("rom_address", {25'd0, rom_address}, {25'd0, exp_addr});
      e_ack = 2'b00;
      if (t >= next_arb && (req[0] || req[1])) begin
        if (req[0] && req[1]) win = FIXED ? 0 : (last_gnt == 1 ? 0 : 1);
        else                  win = req[0] ? 0 : 1;
        e_ack[win]    = 1'b1;
        last_gnt      = win;
        exp_addr      = addr[win];
        due[win]      = t + 3;
        pend_dat[win] = 16'hA500 + {9'd0, addr[win]};
        last_ack      = t;
        next_arb      = t + 3;
      end
      check_eq("ack0", {31'd0, ack0}, {31'd0, e_ack[0]});
      check_eq("ack1", {31'd0, ack1}, {31'd0, e_ack[1]});
    end
  end

  // mode 0: drop req on ack; 1: keep req high with a new address; 2: random traffic.
  task automatic drive_one(input int i, input int mode);
    if (req[i] && seen_ack[i]) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) addr[i] = 7'($urandom);
      else req[i] = 1'b0;
    end else if (mode == 2) begin
      if (!req[i] && $urandom_range(0, 3) == 0) begin
        req[i]  = 1'b1;
        addr[i] = 7'($urandom);
      end else if (req[i] && $urandom_range(0, 15) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic run_cycles(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      drive_one(0, mode);
      drive_one(1, mode);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int i, input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      #1;
      got = (i == 0) ? ack0 : ack1;
    end
    if (!got) check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    req     = 2'b00;
    addr[0] = 7'h00;
    addr[1] = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single requester 0 at address 05.
    req[0] = 1'b1; addr[0] = 7'h05;
    run_cycles(8, 0);

    // Simultaneous after reset: 0 first, then 1 with no IDLE gap.
    do_reset();
    req = 2'b11; addr[0] = 7'h10; addr[1] = 7'h7F;
    run_cycles(10, 0);

    // Both held continuously: alternating grants (fixed build: requester 0 only).
    req = 2'b11;
    run_cycles(13, 1);
    req = 2'b00;
    run_cycles(6, 0);

    // Reset during WAIT of a requester 1 read.
    req[1] = 1'b1; addr[1] = 7'h20;
    wait_ack(1, "rst_case_ack_timeout");
    @(posedge clk); #1; req[1] = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
    run_cycles(6, 0);

    // Requester 1 pulsed for one clk during a GRANT cycle.
    req[0] = 1'b1; addr[0] = 7'h33;
    wait_ack(0, "pulse_case_ack_timeout");
    @(posedge clk); #1; req[0] = 1'b0; req[1] = 1'b1; addr[1] = 7'h44;
    @(posedge clk); #1; req[1] = 1'b0;
    run_cycles(6, 0);

    // Random traffic with a reset in between.
    run_cycles(2000, 2);
    do_reset();
    run_cycles(2000, 2);
    req = 2'b00;
    run_cycles(8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
